// File: rtl/gptp_rx_ts_sched_pkg.sv
// Shared gPTP receive-side types: one-hot frame codes, store slot map,
// scheduler FSM states and the buffered frame record.
package gptp_rx_ts_sched_pkg;

  localparam logic [7:0] TYPE_SYNC  = 8'h01;
  localparam logic [7:0] TYPE_FU    = 8'h02;
  localparam logic [7:0] TYPE_PREQ  = 8'h04;
  localparam logic [7:0] TYPE_PRESP = 8'h88;
  localparam logic [7:0] TYPE_PFU   = 8'h10;

  typedef enum logic [2:0] {
    SLOT_SYNC  = 3'd0,
    SLOT_FU    = 3'd1,
    SLOT_PREQ  = 3'd2,
    SLOT_PRESP = 3'd3,
    SLOT_PFU   = 3'd4
  } slot_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_RX,
    ST_WR_CAR,
    ST_NOTIFY
  } state_e;

  typedef struct packed {
    logic [7:0]  ftype;
    logic [79:0] rx_ts;
    logic [79:0] car_ts;
  } frame_t;

  // Only the five exact codes are accepted; anything else is a drop.
  function automatic logic type_valid(input logic [7:0] t);
    return (t == TYPE_SYNC) || (t == TYPE_FU) || (t == TYPE_PREQ) ||
           (t == TYPE_PRESP) || (t == TYPE_PFU);
  endfunction

  // Slot from the lowest set type bit; bit 7 plays no part.
  function automatic slot_e type_slot(input logic [4:0] b);
    if (b[0])      return SLOT_SYNC;
    else if (b[1]) return SLOT_FU;
    else if (b[2]) return SLOT_PREQ;
    else if (b[3]) return SLOT_PRESP;
    else           return SLOT_PFU;
  endfunction

  // Frames that carry a local receive time (word 0).
  function automatic logic needs_rx(input slot_e s);
    return (s == SLOT_SYNC) || (s == SLOT_PREQ) || (s == SLOT_PRESP);
  endfunction

endpackage

// File: rtl/gptp_rx_ts_sched_frame_fifo.sv
// gptp_rx_frame_fifo: first-word-fall-through frame buffer with a registered
// occupancy count. Push and pop may coincide, including when full.
module gptp_rx_frame_fifo
  import gptp_rx_ts_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  frame_t                     wr_frame,
  input  logic                       pop,
  output frame_t                     rd_frame,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  frame_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, do_push, do_pop;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign rd_frame = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_frame;
  end

endmodule

// File: rtl/gptp_rx_ts_sched.sv
// gptp_rx_ts_sched: buffers decoded frames, writes their timestamps into the
// single-port store, tracks Sync/FU and Pdelay pairing, pulses completion.
// Build option: GPTP_RX_DROP_CNT_EN enables the saturating drop counter.
module gptp_rx_ts_sched
  import gptp_rx_ts_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_frame_vld,
  output logic        rx_frame_rdy,
  input  logic [7:0]  rx_rev_wr_addr,
  input  logic [79:0] rx_rev_wr_data1,
  input  logic [79:0] rx_rev_wr_data2,
  output logic        ts_wr_en,
  input  logic        ts_wr_rdy,
  output logic [3:0]  ts_wr_addr,
  output logic [79:0] ts_wr_data,
  output logic        evt_sync_done,
  output logic        evt_pdly_done,
  output logic [15:0] drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  frame_t        in_frame, head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty, alive, pop, head_ok, wr_word;
  slot_e         head_slot, cur_slot;
  logic [79:0]   cur_rx, cur_car;
  logic          sync_seen, preq_seen, presp_seen;
  state_e        state, nxt;

  assign in_frame  = '{ftype: rx_rev_wr_addr, rx_ts: rx_rev_wr_data1, car_ts: rx_rev_wr_data2};
  assign head_ok   = type_valid(head.ftype);
  assign head_slot = type_slot(head.ftype[4:0]);
  assign pop       = (state == ST_IDLE) & ~fifo_empty;

  // Ready depends only on registered state so the store handshake never
  // reaches the decoder combinationally.
  assign rx_frame_rdy = alive & (fifo_count != CNT_FULL);

  gptp_rx_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rx_frame_vld & rx_frame_rdy),
    .wr_frame (in_frame),
    .pop      (pop),
    .rd_frame (head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Holds ready low through reset and opens it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next state, store write port and completion pulses.
  always_comb begin
    nxt           = state;
    ts_wr_en      = 1'b0;
    wr_word       = 1'b0;
    evt_sync_done = 1'b0;
    evt_pdly_done = 1'b0;
    case (state)
      ST_IDLE:   if (!fifo_empty && head_ok) nxt = needs_rx(head_slot) ? ST_WR_RX : ST_WR_CAR;
      ST_WR_RX: begin
        ts_wr_en = 1'b1;
        if (ts_wr_rdy) nxt = (cur_slot == SLOT_PRESP) ? ST_WR_CAR : ST_NOTIFY;
      end
      ST_WR_CAR: begin
        ts_wr_en = 1'b1;
        wr_word  = 1'b1;
        if (ts_wr_rdy) nxt = ST_NOTIFY;
      end
      ST_NOTIFY: begin
        nxt           = ST_IDLE;
        evt_sync_done = (cur_slot == SLOT_FU)  & sync_seen;
        evt_pdly_done = (cur_slot == SLOT_PFU) & presp_seen;
      end
      default:   nxt = ST_IDLE;
    endcase
    ts_wr_addr = ts_wr_en ? {cur_slot, wr_word} : 4'h0;
    ts_wr_data = ts_wr_en ? (wr_word ? cur_car : cur_rx) : 80'h0;
  end

  // Latch the popped frame so address/data stay put across a stalled write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot <= SLOT_SYNC;
      cur_rx   <= '0;
      cur_car  <= '0;
    end else if (pop && head_ok) begin
      cur_slot <= head_slot;
      cur_rx   <= head.rx_ts;
      cur_car  <= head.car_ts;
    end
  end

  // Exchange pairing, advanced once per stored frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_seen  <= 1'b0;
      preq_seen  <= 1'b0;
      presp_seen <= 1'b0;
    end else if (state == ST_NOTIFY) begin
      case (cur_slot)
        SLOT_SYNC:  sync_seen <= 1'b1;
        SLOT_FU:    sync_seen <= 1'b0;
        SLOT_PREQ:  begin preq_seen <= 1'b1; presp_seen <= 1'b0; end
        SLOT_PRESP: if (preq_seen) presp_seen <= 1'b1;
        SLOT_PFU:   if (presp_seen) begin preq_seen <= 1'b0; presp_seen <= 1'b0; end
        default:    ;
      endcase
    end
  end

`ifdef GPTP_RX_DROP_CNT_EN
  logic [15:0] drop_q;

  // Count discarded frames, sticking at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    drop_q <= '0;
    else if (pop && !head_ok && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_gptp_rx_ts_sched.sv
// Bench for gptp_rx_ts_sched: directed vector table, stall/reset sequences,
// and randomized traffic checked against a frame-level pairing model.
module tb_gptp_rx_ts_sched;

`ifdef GPTP_RX_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_frame_vld = 1'b0;
  logic        rx_frame_rdy;
  logic [7:0]  rx_type = 8'h0;
  logic [79:0] d1 = '0, d2 = '0;
  logic        ts_wr_en, ts_wr_rdy;
  logic [3:0]  ts_wr_addr;
  logic [79:0] ts_wr_data;
  logic        evt_sync_done, evt_pdly_done;
  logic [15:0] drop_cnt;
  logic        man_rdy = 1'b1, rnd_rdy = 1'b0, rnd_mode = 1'b0;
  int          cyc = 0;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign ts_wr_rdy = rnd_mode ? rnd_rdy : man_rdy;

  gptp_rx_ts_sched #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_frame_vld(rx_frame_vld), .rx_frame_rdy(rx_frame_rdy),
    .rx_rev_wr_addr(rx_type), .rx_rev_wr_data1(d1), .rx_rev_wr_data2(d2),
    .ts_wr_en(ts_wr_en), .ts_wr_rdy(ts_wr_rdy), .ts_wr_addr(ts_wr_addr), .ts_wr_data(ts_wr_data),
    .evt_sync_done(evt_sync_done), .evt_pdly_done(evt_pdly_done), .drop_cnt(drop_cnt)
  );

  typedef struct { logic [7:0] t; logic [79:0] d1; logic [79:0] d2; int cyc; } acc_t;
  typedef struct { logic [3:0] a; logic [79:0] d; int cyc; } wr_t;
  typedef struct { int kind; int cyc; } ev_t;
  typedef struct {
    logic [7:0] t; logic [79:0] d1; logic [79:0] d2;
    int nwr; logic [3:0] a0; logic [3:0] a1; logic [79:0] w0; logic [79:0] w1;
    int nsync; int npdly;
  } vec_t;

  acc_t acc_q[$];
  wr_t  wr_q[$];
  ev_t  ev_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

  // Passive observer: accepted frames, completed writes, event pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_frame_vld && rx_frame_rdy) acc_q.push_back('{rx_type, d1, d2, cyc});
      if (ts_wr_en && ts_wr_rdy)        wr_q.push_back('{ts_wr_addr, ts_wr_data, cyc});
      if (evt_sync_done)                ev_q.push_back('{1, cyc});
      if (evt_pdly_done)                ev_q.push_back('{2, cyc});
    end
  end

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_drop(input int n);
    return DROP_EN ? n : 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one frame and hold it until the edge that accepts it.
  task automatic send(input logic [7:0] t, input logic [79:0] a, input logic [79:0] b);
    bit took;
    int g;
    rx_frame_vld = 1'b1; rx_type = t; d1 = a; d2 = b;
    took = 1'b0;
    for (g = 0; g < 200 && !took; g++) begin
      took = rx_frame_rdy;
      @(posedge clk);
      #1;
    end
    rx_frame_vld = 1'b0;
    if (!took) begin
      errors++; checks++;
      $display("FAIL send_timeout: type %h not accepted within 200 cycles", t);
    end
  endtask

  // Frame-level reference: expected writes and events follow from the type
  // sequence and the pairing rules alone, compared in order.
  task automatic check_segment(input string tag, input int a_lo, input int w_lo,
                               input int e_lo, output int drops);
    wr_t ew[$];
    ev_t ee[$];
    bit s_seen, q_seen, r_seen;
    int nw, ne, nb;
    acc_t f;
    s_seen = 0; q_seen = 0; r_seen = 0; drops = 0;
    for (int i = a_lo; i < acc_q.size(); i++) begin
      f = acc_q[i];
      case (f.t)
        8'h01: begin ew.push_back('{4'h0, f.d1, 0}); s_seen = 1; end
        8'h02: begin
          ew.push_back('{4'h3, f.d2, 0});
          if (s_seen) ee.push_back('{1, ew.size()});
          s_seen = 0;
        end
        8'h04: begin ew.push_back('{4'h4, f.d1, 0}); q_seen = 1; r_seen = 0; end
        8'h88: begin
          ew.push_back('{4'h6, f.d1, 0});
          ew.push_back('{4'h7, f.d2, 0});
          if (q_seen) r_seen = 1;
        end
        8'h10: begin
          ew.push_back('{4'h9, f.d2, 0});
          if (r_seen) begin ee.push_back('{2, ew.size()}); q_seen = 0; r_seen = 0; end
        end
        default: drops++;
      endcase
    end
    nw = wr_q.size() - w_lo;
    chk_i({tag, "_nwr"}, nw, ew.size());
    for (int i = 0; i < nw && i < ew.size(); i++) begin
      chk_i({tag, "_addr"}, int'(wr_q[w_lo+i].a), int'(ew[i].a));
      chk_d({tag, "_data"}, wr_q[w_lo+i].d, ew[i].d);
    end
    ne = ev_q.size() - e_lo;
    chk_i({tag, "_nevt"}, ne, ee.size());
    for (int i = 0; i < ne && i < ee.size(); i++) begin
      chk_i({tag, "_evt_kind"}, ev_q[e_lo+i].kind, ee[i].kind);
      nb = 0;
      for (int j = w_lo; j < wr_q.size(); j++) if (wr_q[j].cyc < ev_q[e_lo+i].cyc) nb++;
      chk_i({tag, "_evt_after_writes"}, nb, ee[i].cyc);
    end
  endtask

  localparam logic [79:0] DA = 80'h0123_4567_89AB_CDEF_00AA;
  localparam logic [79:0] DB = 80'h1111_2222_3333_4444_55BB;
  localparam logic [79:0] DC = 80'h7777_6666_5555_4444_33CC;
  localparam logic [79:0] DD = 80'h9999_8888_7777_6666_55DD;
  localparam logic [79:0] X1 = 80'hA5A5_A5A5_A5A5_A5A5_0001;
  localparam logic [79:0] X2 = 80'h5A5A_5A5A_5A5A_5A5A_0002;
  localparam logic [79:0] J1 = 80'hDEAD_BEEF_DEAD_BEEF_0BAD;

  initial begin
    vec_t        vecs[11];
    logic [7:0]  codes[5];
    logic [3:0]  cap_a;
    logic [79:0] cap_d, ra, rb;
    logic [7:0]  rt;
    int a0, w0, e0, drops, nw, g;
    bit found;

    vecs[0]  = '{8'h01, DA, J1, 1, 4'h0, 4'h0, DA, 80'h0, 0, 0};
    vecs[1]  = '{8'h02, J1, DB, 1, 4'h3, 4'h0, DB, 80'h0, 1, 0};
    vecs[2]  = '{8'h04, DC, J1, 1, 4'h4, 4'h0, DC, 80'h0, 0, 0};
    vecs[3]  = '{8'h88, X1, X2, 2, 4'h6, 4'h7, X1, X2,    0, 0};
    vecs[4]  = '{8'h10, J1, DD, 1, 4'h9, 4'h0, DD, 80'h0, 0, 1};
    vecs[5]  = '{8'h08, DA, DB, 0, 4'h0, 4'h0, 80'h0, 80'h0, 0, 0};
    vecs[6]  = '{8'h03, DA, DB, 0, 4'h0, 4'h0, 80'h0, 80'h0, 0, 0};
    vecs[7]  = '{8'h02, J1, DB, 1, 4'h3, 4'h0, DB, 80'h0, 0, 0};
    vecs[8]  = '{8'h00, DA, DB, 0, 4'h0, 4'h0, 80'h0, 80'h0, 0, 0};
    vecs[9]  = '{8'h80, DA, DB, 0, 4'h0, 4'h0, 80'h0, 80'h0, 0, 0};
    vecs[10] = '{8'h10, J1, DD, 1, 4'h9, 4'h0, DD, 80'h0, 0, 0};
    codes = '{8'h01, 8'h02, 8'h04, 8'h88, 8'h10};

    // Reset state
    tick(3);
    chk_i("rst_rdy", int'(rx_frame_rdy), 0);
    chk_i("rst_wr_en", int'(ts_wr_en), 0);
    chk_i("rst_addr", int'(ts_wr_addr), 0);
    chk_d("rst_data", ts_wr_data, 80'h0);
    chk_i("rst_evts", int'({evt_sync_done, evt_pdly_done}), 0);
    chk_i("rst_drop", int'(drop_cnt), 0);
    rst_n = 1'b1;
    tick(1);
    chk_i("rdy_after_rst", int'(rx_frame_rdy), 1);

    // Directed vectors, one frame at a time with the store always ready
    for (int i = 0; i < 11; i++) begin
      a0 = acc_q.size(); w0 = wr_q.size(); e0 = ev_q.size();
      send(vecs[i].t, vecs[i].d1, vecs[i].d2);
      tick(8);
      chk_i($sformatf("v%0d_acc", i), acc_q.size() - a0, 1);
      nw = wr_q.size() - w0;
      chk_i($sformatf("v%0d_nwr", i), nw, vecs[i].nwr);
      if (nw > 0 && vecs[i].nwr > 0 && acc_q.size() > a0) begin
        chk_i($sformatf("v%0d_a0", i), int'(wr_q[w0].a), int'(vecs[i].a0));
        chk_d($sformatf("v%0d_w0", i), wr_q[w0].d, vecs[i].w0);
        chk_i($sformatf("v%0d_lat0", i), wr_q[w0].cyc - acc_q[a0].cyc, 2);
      end
      if (nw > 1 && vecs[i].nwr > 1 && acc_q.size() > a0) begin
        chk_i($sformatf("v%0d_a1", i), int'(wr_q[w0+1].a), int'(vecs[i].a1));
        chk_d($sformatf("v%0d_w1", i), wr_q[w0+1].d, vecs[i].w1);
        chk_i($sformatf("v%0d_lat1", i), wr_q[w0+1].cyc - acc_q[a0].cyc, 3);
      end
      chk_i($sformatf("v%0d_nevt", i), ev_q.size() - e0, vecs[i].nsync + vecs[i].npdly);
      if (ev_q.size() > e0 && acc_q.size() > a0) begin
        chk_i($sformatf("v%0d_evt_kind", i), ev_q[e0].kind, vecs[i].nsync ? 1 : 2);
        chk_i($sformatf("v%0d_evt_lat", i), ev_q[e0].cyc - acc_q[a0].cyc, 3);
      end
      if (i == 6) chk_i("drop_cnt_after_2", int'(drop_cnt), exp_drop(2));
    end

    // Back-to-back single-write frames: one store write every third cycle
    w0 = wr_q.size();
    send(8'h01, DA, J1); send(8'h01, DB, J1); send(8'h01, DC, J1);
    tick(12);
    chk_i("tput_nwr", wr_q.size() - w0, 3);
    if (wr_q.size() - w0 == 3) begin
      chk_i("tput_gap1", wr_q[w0+1].cyc - wr_q[w0].cyc, 3);
      chk_i("tput_gap2", wr_q[w0+2].cyc - wr_q[w0+1].cyc, 3);
    end

    // Store stalled during PResp with two more frames queued behind it
    man_rdy = 1'b0;
    send(8'h88, X1, X2); send(8'h01, DA, J1); send(8'h02, J1, DB);
    chk_i("stall_full_rdy", int'(rx_frame_rdy), 0);
    found = 0;
    for (g = 0; g < 10 && !found; g++) begin
      if (ts_wr_en) found = 1; else tick(1);
    end
    chk_i("stall_en_seen", int'(found), 1);
    cap_a = ts_wr_addr; cap_d = ts_wr_data;
    chk_i("stall_addr", int'(cap_a), 6);
    chk_d("stall_data", cap_d, X1);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      chk_i("stall_en_hold", int'(ts_wr_en), 1);
      chk_i("stall_addr_hold", int'(ts_wr_addr), int'(cap_a));
      chk_d("stall_data_hold", ts_wr_data, cap_d);
      chk_i("stall_rdy_hold", int'(rx_frame_rdy), 0);
    end
    man_rdy = 1'b1;
    tick(15);

    check_segment("segA", 0, 0, 0, drops);
    chk_i("segA_drop_cnt", int'(drop_cnt), exp_drop(drops));

    // Reset asserted mid-cycle while the carried-time write is stalled
    send(8'h01, DA, J1);
    tick(6);
    man_rdy = 1'b0;
    send(8'h88, X1, X2);
    found = 0;
    for (g = 0; g < 10 && !found; g++) begin
      if (ts_wr_en && ts_wr_addr == 4'h6) found = 1; else tick(1);
    end
    chk_i("rstwr_rx_seen", int'(found), 1);
    man_rdy = 1'b1;
    tick(1);
    man_rdy = 1'b0;
    chk_i("rstwr_in_car", int'(ts_wr_en && ts_wr_addr == 4'h7), 1);
    #3 rst_n = 1'b0;
    #1;
    chk_i("async_rst_en", int'(ts_wr_en), 0);
    chk_i("async_rst_addr", int'(ts_wr_addr), 0);
    chk_d("async_rst_data", ts_wr_data, 80'h0);
    chk_i("async_rst_rdy", int'(rx_frame_rdy), 0);
    tick(2);
    chk_i("rst_drop_clr", int'(drop_cnt), 0);
    a0 = acc_q.size(); w0 = wr_q.size(); e0 = ev_q.size();
    rst_n = 1'b1;
    man_rdy = 1'b1;
    tick(1);
    chk_i("rdy_after_rst2", int'(rx_frame_rdy), 1);
    send(8'h02, J1, DB);
    tick(8);
    chk_i("post_rst_fu_nwr", wr_q.size() - w0, 1);
    if (wr_q.size() > w0) chk_i("post_rst_fu_addr", int'(wr_q[w0].a), 3);
    chk_i("post_rst_fu_noevt", ev_q.size() - e0, 0);

    // Randomized traffic with a randomly stalling store
    rnd_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 8) rt = codes[$urandom_range(0, 4)];
      else                          rt = 8'($urandom_range(0, 255));
      ra = {$urandom(), $urandom(), 16'($urandom())};
      rb = {$urandom(), $urandom(), 16'($urandom())};
      send(rt, ra, rb);
      tick($urandom_range(0, 3));
    end
    rnd_mode = 1'b0;
    man_rdy = 1'b1;
    tick(40);
    check_segment("segB", a0, w0, e0, drops);
    chk_i("segB_drop_cnt", int'(drop_cnt), exp_drop(drops));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gptp_rx_ts_sched.md
# gptp_rx_ts_sched

Receive-side timestamp write scheduler for the gPTP core. It sits between the frame decoder and the single-port 80-bit timestamp store. Each frame arrives as a one-hot type code plus two 80-bit timestamps: the local receive time and the timestamp carried in the frame. The block buffers frames, issues one or two store writes per frame, tracks Sync/Follow_Up and Pdelay exchange pairing, and pulses completion events to the sync and pdelay engines.

## Interface
Parameters:
- FIFO_DEPTH, 2: input frame buffer depth; power of two, ≥2.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- rx_frame_vld  in  1  decoded frame present
- rx_frame_rdy  out  1  buffer can accept; a frame transfers when vld & rdy
- rx_rev_wr_addr  in  8  one-hot frame type: 0x01 Sync, 0x02 Follow_Up, 0x04 Pdelay_Req, 0x88 Pdelay_Resp, 0x10 Pdelay_Resp_Follow_Up
- rx_rev_wr_data1  in  80  local receive timestamp
- rx_rev_wr_data2  in  80  timestamp carried in the frame
- ts_wr_en  out  1  store write request
- ts_wr_rdy  in  1  store accepts; a write completes when en & rdy
- ts_wr_addr  out  4  {slot[2:0], word}; word 0 = rx time, word 1 = carried time
- ts_wr_data  out  80  write data
- evt_sync_done  out  1  one-cycle pulse: Sync+Follow_Up pair stored
- evt_pdly_done  out  1  one-cycle pulse: Req+Resp+Resp_FU set stored
- drop_cnt  out  16  unrecognised frames dropped

## Operation
- Slot map, from type bit 0..4: Sync=0, FU=1, PReq=2, PResp=3, PFU=4. Bit 7 is ignored for decoding; PResp is recognised by bit 3.
- Valid codes are exactly 0x01, 0x02, 0x04, 0x88 and 0x10. Any other code, including 0x00, 0x08 and multi-bit values, is accepted, then discarded at pop and counted as a drop. No write and no event results.
- Writes per type:
  - Sync, PReq: word 0 only (data1).
  - FU, PFU: word 1 only (data2).
  - PResp: word 0 then word 1.
- FSM states are IDLE, WR_RX, WR_CAR, NOTIFY.
  - IDLE: when the FIFO is non-empty, pop. The next state is WR_RX if the frame needs word 0, else WR_CAR. Drops stay in IDLE.
  - WR_RX: hold ts_wr_en with address and data stable until ts_wr_rdy. Then go to WR_CAR if PResp, else NOTIFY.
  - WR_CAR: same handshake rule, then go to NOTIFY.
  - NOTIFY: update pairing flags, pulse events if due, go to IDLE.
- Pairing flags, set or cleared in NOTIFY:
  - Sync sets sync_seen.
  - FU with sync_seen pulses evt_sync_done and clears sync_seen. FU without sync_seen produces no event.
  - PReq sets preq_seen and clears presp_seen.
  - PResp with preq_seen sets presp_seen.
  - PFU with presp_seen pulses evt_pdly_done and clears both flags.
  - A second Sync before its FU simply re-sets sync_seen; the store slot is overwritten.
- Simultaneous accept and pop in the same cycle is legal when the FIFO is full. rx_frame_rdy is computed from the registered count only; no combinational path from ts_wr_rdy.

## Timing
- Reset values: rx_frame_rdy=0 during reset and 1 in the first cycle after deassertion. All other outputs are 0, flags are clear, FIFO is empty, state is IDLE.
- Frame accepted at edge N, FIFO visible at N+1, popped in IDLE at N+1, ts_wr_en high from N+2.
- With ts_wr_rdy tied high:
  - single-write frame: event at N+3, IDLE at N+4.
  - PResp: event at N+4, IDLE at N+5.
- Sustained throughput with rdy high: one single-write frame per 3 cycles.
- ts_wr_rdy low stalls indefinitely. ts_wr_en never drops, and address/data never change, before the handshake.
- rst_n assertion mid-write abandons the frame, clears the FIFO and flags, and drops ts_wr_en immediately (asynchronously).

## Configuration
- GPTP_RX_DROP_CNT_EN defined: drop_cnt is a 16-bit counter, incremented on each dropped frame and saturating at 0xFFFF.
- GPTP_RX_DROP_CNT_EN undefined: drop_cnt is tied to 0 and no counter registers exist. Drops still occur.

## Structure
- Shared gptp package holds:
  - the one-hot type constants (SYNC=8'h01, FU=8'h02, PREQ=8'h04, PRESP=8'h88, PFU=8'h10);
  - the slot enum and the FSM state typedef;
  - a frame struct {type[7:0], rx_ts[79:0], car_ts[79:0]}.
- One sub-module: gptp_rx_frame_fifo, a synchronous FIFO of FIFO_DEPTH×168 bits with full/empty and a registered count.

## Test plan
- Sync 0x01 with data1=0x…AA, ts_wr_rdy=1 -> one write addr 0x0 data 0x…AA; no event.
- Sync then FU 0x02 with data2=0x…BB -> FU write addr 0x3 data 0x…BB; evt_sync_done pulses exactly once.
- PReq, then PResp 0x88 (data1=X1, data2=X2), then PFU -> writes to 0x4, 0x6=X1, 0x7=X2, 0x9; evt_pdly_done pulses once, after the PFU write.
- Code 0x08, then 0x03 -> no writes; drop_cnt=2 with the macro defined, 0 without.
- ts_wr_rdy held low 10 cycles during a PResp, with 2 more frames queued -> rx_frame_rdy=0 once full; ts_wr_en, address and data stable; all writes complete in order after release.
- rst_n pulsed low while in WR_CAR -> outputs 0 asynchronously; a subsequent FU gives no evt_sync_done.
